// File: rtl/dummy_accel.sv
// dummy_accel: registered unsigned adder with a parameterisable delay line.
// Stage 0 registers the full-precision sum, and the remaining stages only
// delay it. The output comes straight from the last stage, so no
// combinational path runs from a/b to sum.
module dummy_accel #(
    parameter int DATA_W      = 8,
    parameter int PIPE_STAGES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W:0]   sum
);

    // Reject an unsupported pipeline depth when the design is elaborated.
    generate
        if (PIPE_STAGES < 1 || PIPE_STAGES > 8) begin : g_bad_depth
            $error("dummy_accel: PIPE_STAGES must be in the range 1..8");
        end
    endgenerate

    logic [DATA_W:0] sum_next;

    // Widen both operands before adding, so the carry lands in the MSB.
    always_comb begin
        sum_next = {1'b0, a} + {1'b0, b};
    end

    genvar gi;
    generate
        for (gi = 0; gi < PIPE_STAGES; gi++) begin : g_stage
            logic [DATA_W:0] stage_reg;

            if (gi == 0) begin : g_first
                // Capture the sum of the operands present at this edge.
                // Reset clears the register asynchronously.
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        stage_reg <= '0;
                    end else begin
                        stage_reg <= sum_next;
                    end
                end
            end else begin : g_delay
                // Plain delay register. Reset clears it, so no stale
                // result can come out after reset is released.
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        stage_reg <= '0;
                    end else begin
                        stage_reg <= g_stage[gi-1].stage_reg;
                    end
                end
            end
        end
    endgenerate

    assign sum = g_stage[PIPE_STAGES-1].stage_reg;

endmodule

// File: tb/tb_dummy_accel.sv
// Directed testbench for dummy_accel. It drives two instances from the same
// inputs: one at the default depth of 1 and one with PIPE_STAGES = 3.
// Expected values are worked out by hand from the operands.
module tb_dummy_accel;

    logic       clk;
    logic       rst_n;
    logic [7:0] a;
    logic [7:0] b;
    logic [8:0] sum1;
    logic [8:0] sum3;

    int checks   = 0;
    int failures = 0;

    dummy_accel #(.DATA_W(8), .PIPE_STAGES(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .b     (b),
        .sum   (sum1)
    );

    dummy_accel #(.DATA_W(8), .PIPE_STAGES(3)) dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .b     (b),
        .sum   (sum3)
    );

    // 10 time-unit clock period; rising edges fall at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [8:0] observed, input logic [8:0] expected);
        checks++;
        assert (observed === expected)
            $display("check %-16s observed=%0d expected=%0d ok", tag, observed, expected);
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // The bench enters reset before any clock edge occurs.
        rst_n = 1'b0;
        a     = 8'd0;
        b     = 8'd0;
        #1;
        check("rst_noclk_p1", sum1, 9'd0);
        check("rst_noclk_p3", sum3, 9'd0);
        step();
        step();
        check("rst_hold_p1", sum1, 9'd0);
        check("rst_hold_p3", sum3, 9'd0);

        // Operands that toggle during reset are ignored.
        a = 8'd10; b = 8'd5;
        step();
        check("rst_ignore_p1", sum1, 9'd0);
        check("rst_ignore_p3", sum3, 9'd0);

        // Release reset away from the clock edge. This edge samples 10+5.
        rst_n = 1'b1;
        step();
        check("basic_p1", sum1, 9'd15);
        check("basic_p3_e1", sum3, 9'd0);

        // Back-to-back vectors.
        a = 8'd100; b = 8'd7;
        step();
        check("b2b_107_p1", sum1, 9'd107);
        check("b2b_p3_e2", sum3, 9'd0);
        a = 8'd255; b = 8'd1;
        step();
        check("b2b_256_p1", sum1, 9'd256);
        check("b2b_p3_e3", sum3, 9'd15);
        step();
        check("b2b_hold_p1", sum1, 9'd256);
        check("b2b_p3_e4", sum3, 9'd107);

        // Carry and extreme values.
        a = 8'd255; b = 8'd255;
        step();
        check("carry_510_p1", sum1, 9'h1FE);
        check("carry_p3_e5", sum3, 9'd256);
        a = 8'd0; b = 8'd0;
        step();
        check("zero_p1", sum1, 9'd0);
        check("zero_p3_e6", sum3, 9'd256);

        // Glitches between edges have no effect. Only the settled value counts.
        a = 8'd1;   b = 8'd200;
        #2;
        a = 8'd200; b = 8'd1;
        #2;
        a = 8'd20;  b = 8'd22;
        step();
        check("glitch_p1", sum1, 9'd42);

        // Mid-stream reset, asserted between edges.
        a = 8'd50; b = 8'd60;
        step();
        check("stream_p1", sum1, 9'd110);
        a = 8'd70; b = 8'd80;
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_async_p1", sum1, 9'd0);
        check("midrst_async_p3", sum3, 9'd0);
        step();
        check("midrst_edge_p1", sum1, 9'd0);
        check("midrst_edge_p3", sum3, 9'd0);

        // After release, the first result is the first post-release sample.
        a = 8'd3; b = 8'd4;
        rst_n = 1'b1;
        step();
        check("post_rst_p1", sum1, 9'd7);
        check("post_rst_p3_r1", sum3, 9'd0);
        a = 8'd0; b = 8'd0;
        step();
        check("post_rst_p3_r2", sum3, 9'd0);
        step();
        check("post_rst_p3_r3", sum3, 9'd7);

        // Latency at 3 stages: one sample of 100+7, surrounded by zeros.
        a = 8'd100; b = 8'd7;
        step();
        check("lat_p1", sum1, 9'd107);
        check("lat_p3_s0", sum3, 9'd0);
        a = 8'd0; b = 8'd0;
        step();
        check("lat_p3_s1", sum3, 9'd0);
        step();
        check("lat_p3_s2", sum3, 9'd107);
        step();
        check("lat_p3_s3", sum3, 9'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
